// File: rtl/audio_beep_sequencer.sv
// Audio beep burst sequencer: counts tone periods and feeds the PWM modulator
// a reference level that is silent in the first half of each tone period.
//
// state | meaning
// IDLE  | waiting for start; contador and pwm_ref held at 0
// TONE  | beep active; level emitted while contador >= HALF
// GAP   | silent spacing between consecutive beeps
module audio_beep_sequencer #(
  parameter int TONE_PERIOD = 64000,
  parameter int HALF        = 32000,
  parameter int TONE_CYCLES = 100,
  parameter int GAP_CYCLES  = 50
) (
  input  logic        clk,
  input  logic        reset_central,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  num_beeps,
  input  logic [4:0]  level,
  output logic [15:0] contador,
  output logic [4:0]  pwm_ref,
  output logic        busy,
  output logic        done,
  output logic [3:0]  beep_idx
);

  localparam logic [15:0] WRAP_VAL  = 16'(TONE_PERIOD - 1);
  localparam logic [15:0] HALF_VAL  = 16'(HALF);
  localparam logic [15:0] TONE_LAST = 16'(TONE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] cyc_cnt;
  logic [3:0]  num_lat;
  logic [4:0]  level_lat;

  logic period_wrap;
  logic tone_last;
  logic gap_last;
  logic beep_last;

  assign period_wrap = (contador == WRAP_VAL);
  assign tone_last   = (cyc_cnt == TONE_LAST);
  assign gap_last    = (cyc_cnt == GAP_LAST);
  assign beep_last   = (beep_idx == (num_lat - 4'd1));

  always_ff @(posedge clk) begin
    if (reset_central) begin
      state     <= IDLE;
      contador  <= '0;
      pwm_ref   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      beep_idx  <= '0;
      cyc_cnt   <= '0;
      num_lat   <= '0;
      level_lat <= '0;
    end else if (abort && (state != IDLE)) begin
      state    <= IDLE;
      contador <= '0;
      pwm_ref  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      beep_idx <= '0;
      cyc_cnt  <= '0;
    end else begin
      done <= 1'b0;
      // pwm_ref lags the state/counter pair by exactly one cycle
      pwm_ref <= ((state == TONE) && (contador >= HALF_VAL)) ? level_lat : '0;

      case (state)
        IDLE: begin
          contador <= '0;
          cyc_cnt  <= '0;
          beep_idx <= '0;
          busy     <= 1'b0;
          if (start && !abort) begin
            if (num_beeps != 4'd0) begin
              num_lat   <= num_beeps;
              level_lat <= level;
              state     <= TONE;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end

        TONE: begin
          if (period_wrap) begin
            contador <= '0;
            if (tone_last) begin
              cyc_cnt <= '0;
              if (beep_last) begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                beep_idx <= '0;
              end else begin
                state <= GAP;
              end
            end else begin
              cyc_cnt <= cyc_cnt + 16'd1;
            end
          end else begin
            contador <= contador + 16'd1;
          end
        end

        GAP: begin
          if (period_wrap) begin
            contador <= '0;
            if (gap_last) begin
              cyc_cnt  <= '0;
              state    <= TONE;
              beep_idx <= beep_idx + 4'd1;
            end else begin
              cyc_cnt <= cyc_cnt + 16'd1;
            end
          end else begin
            contador <= contador + 16'd1;
          end
        end

        default: begin
          state    <= IDLE;
          contador <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_beep_sequencer.sv
// Bench for audio_beep_sequencer: vector table, hand sequences, randomized bursts
// against a timeline model, and a full-width 16-bit wrap instance.
module tb_audio_beep_sequencer;

  localparam int P  = 8;
  localparam int H  = 4;
  localparam int TC = 2;
  localparam int GC = 1;
  localparam int BL = TC * P;
  localparam int GL = GC * P;

  logic        clk = 1'b0;
  logic        reset_central = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  num_beeps = '0;
  logic [4:0]  level = '0;
  logic [15:0] contador;
  logic [4:0]  pwm_ref;
  logic        busy;
  logic        done;
  logic [3:0]  beep_idx;

  logic        reset_w = 1'b1;
  logic        start_w = 1'b0;
  logic        abort_w = 1'b0;
  logic [3:0]  num_w = '0;
  logic [4:0]  level_w = '0;
  logic [15:0] contador_w;
  logic [4:0]  pwm_w;
  logic        busy_w;
  logic        done_w;
  logic [3:0]  idx_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_beep_sequencer #(.TONE_PERIOD(P), .HALF(H), .TONE_CYCLES(TC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset_central(reset_central), .start(start), .abort(abort),
    .num_beeps(num_beeps), .level(level), .contador(contador), .pwm_ref(pwm_ref),
    .busy(busy), .done(done), .beep_idx(beep_idx)
  );

  audio_beep_sequencer #(.TONE_PERIOD(65536), .HALF(32000), .TONE_CYCLES(1), .GAP_CYCLES(1)) dut_w (
    .clk(clk), .reset_central(reset_w), .start(start_w), .abort(abort_w),
    .num_beeps(num_w), .level(level_w), .contador(contador_w), .pwm_ref(pwm_w),
    .busy(busy_w), .done(done_w), .beep_idx(idx_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: start accepted at cycle 0; outputs at cycle t follow from
  // beep/gap lengths with plain division, independent of any counter structure.
  typedef struct {
    int busy;
    int done;
    int cnt;
    int idx;
    int tone;
  } exp_t;

  function automatic exp_t model(int t, int n, int abort_at);
    exp_t e;
    int u, total, k, r;
    e = '{0, 0, 0, 0, 0};
    if (t <= 0) return e;
    if (n == 0) begin
      e.done = (t == 1) ? 1 : 0;
      return e;
    end
    if (abort_at >= 0 && t > abort_at) return e;
    u = t - 1;
    total = n * BL + (n - 1) * GL;
    if (u < total) begin
      e.busy = 1;
      k = u / (BL + GL);
      r = u % (BL + GL);
      e.idx = k;
      if (r < BL) begin
        e.tone = 1;
        e.cnt = r % P;
      end else begin
        e.cnt = (r - BL) % P;
      end
    end else if (u == total) begin
      e.done = 1;
    end
    return e;
  endfunction

  function automatic int model_pwm(int t, int n, int lvl, int abort_at);
    exp_t p;
    if (abort_at >= 0 && t > abort_at) return 0;
    p = model(t - 1, n, abort_at);
    return (p.tone == 1 && p.cnt >= H) ? lvl : 0;
  endfunction

  typedef struct {
    int n;
    int lvl;
    bit abort_with_start;
    int abort_at;
    int exp_done;
    int exp_busy;
    int exp_pwm_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic main_test();
    exp_t e;
    int done_at, done_cnt, busy_cnt, pwm_sum, overlap, total, abort_at, len, n, lvl;

    tick();
    tick();
    chk("reset_contador", 32'(contador), 32'd0);
    chk("reset_pwm", 32'(pwm_ref), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    reset_central = 1'b0;
    tick();

    vecs[0] = '{1, 6, 1'b0, -1, 17, 16, 48};
    vecs[1] = '{2, 31, 1'b0, -1, 41, 40, 496};
    vecs[2] = '{3, 9, 1'b0, 10, -1, 10, 36};
    vecs[3] = '{1, 12, 1'b0, -1, 17, 16, 96};
    vecs[4] = '{0, 5, 1'b0, -1, 1, 0, 0};
    vecs[5] = '{1, 6, 1'b1, -1, -1, 0, 0};

    foreach (vecs[i]) begin
      start = 1'b1;
      abort = vecs[i].abort_with_start;
      num_beeps = 4'(vecs[i].n);
      level = 5'(vecs[i].lvl);
      done_at = -1; done_cnt = 0; busy_cnt = 0; pwm_sum = 0; overlap = 0;
      for (int t = 1; t <= 48; t++) begin
        tick();
        start = 1'b0;
        if (done) begin
          done_cnt++;
          if (done_at < 0) done_at = t;
        end
        busy_cnt += int'(busy);
        pwm_sum += int'(pwm_ref);
        if (done && busy) overlap++;
        abort = (t == vecs[i].abort_at);
      end
      abort = 1'b0;
      chk($sformatf("vec%0d_done_cycle", i), 32'(done_at), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d_done_count", i), 32'(done_cnt), (vecs[i].exp_done >= 0) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_pwm_sum", i), 32'(pwm_sum), 32'(vecs[i].exp_pwm_sum));
      chk($sformatf("vec%0d_done_busy_overlap", i), 32'(overlap), 32'd0);
    end

    // reset held two cycles mid-tone
    start = 1'b1; num_beeps = 4'd2; level = 5'd7;
    for (int t = 1; t <= 6; t++) begin
      tick();
      start = 1'b0;
    end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_central = 1'b1;
    tick();
    chk("midreset_contador", 32'(contador), 32'd0);
    chk("midreset_pwm", 32'(pwm_ref), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_idx", 32'(beep_idx), 32'd0);
    tick();
    reset_central = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      done_cnt += int'(done);
      busy_cnt += int'(busy);
    end
    chk("post_reset_no_done", 32'(done_cnt), 32'd0);
    chk("post_reset_idle", 32'(busy_cnt), 32'd0);

    // start re-pulse with new values during a burst is ignored
    start = 1'b1; num_beeps = 4'd1; level = 5'd6;
    for (int t = 1; t <= 18; t++) begin
      tick();
      start = (t == 5);
      if (t == 5) begin
        level = 5'd3;
        num_beeps = 4'd2;
      end
      if (t == 6) chk("repulse_pwm_c6", 32'(pwm_ref), 32'd6);
      if (t == 14) chk("repulse_pwm_c14", 32'(pwm_ref), 32'd6);
      if (t == 17) chk("repulse_done_c17", 32'(done), 32'd1);
    end

    // two beeps: gap and beep index advance
    start = 1'b1; num_beeps = 4'd2; level = 5'd31;
    for (int t = 1; t <= 42; t++) begin
      tick();
      start = 1'b0;
      if (t == 20) chk("gap_pwm_c20", 32'(pwm_ref), 32'd0);
      if (t == 20) chk("gap_busy_c20", 32'(busy), 32'd1);
      if (t == 24) chk("gap_idx_c24", 32'(beep_idx), 32'd0);
      if (t == 25) chk("beep2_idx_c25", 32'(beep_idx), 32'd1);
      if (t == 25) chk("beep2_contador_c25", 32'(contador), 32'd0);
      if (t == 41) chk("two_done_c41", 32'(done), 32'd1);
    end

    // randomized bursts against the timeline model
    for (int b = 0; b < 25; b++) begin
      n = $urandom_range(0, 4);
      lvl = $urandom_range(0, 31);
      total = (n == 0) ? 0 : n * BL + (n - 1) * GL;
      abort_at = (n > 0 && ($urandom % 3) == 0) ? $urandom_range(1, total) : -1;
      len = total + 4;
      start = 1'b1; abort = 1'b0;
      num_beeps = 4'(n); level = 5'(lvl);
      for (int t = 1; t <= len; t++) begin
        tick();
        e = model(t, n, abort_at);
        chk("rnd_busy", 32'(busy), 32'(e.busy));
        chk("rnd_done", 32'(done), 32'(e.done));
        chk("rnd_contador", 32'(contador), 32'(e.cnt));
        chk("rnd_idx", 32'(beep_idx), 32'(e.idx));
        chk("rnd_pwm", 32'(pwm_ref), 32'(model_pwm(t, n, lvl, abort_at)));
        start = 1'b0;
        if (e.busy == 1) begin
          num_beeps = 4'($urandom);
          level = 5'($urandom);
          start = (($urandom % 4) == 0);
        end
        abort = (t == abort_at) || (e.busy == 0 && ($urandom % 5) == 0);
      end
      start = 1'b0; abort = 1'b0;
      tick();
    end
  endtask

  task automatic wrap_test();
    int errs;
    int exp_cnt, exp_pwm, exp_busy, exp_done;
    errs = 0;
    tick();
    tick();
    reset_w = 1'b0;
    start_w = 1'b1; num_w = 4'd1; level_w = 5'd21;
    for (int t = 1; t <= 65540; t++) begin
      tick();
      start_w = 1'b0;
      exp_cnt = (t <= 65536) ? t - 1 : 0;
      exp_pwm = (t >= 2 && t <= 65537 && (t - 2) >= 32000) ? 21 : 0;
      exp_busy = (t <= 65536) ? 1 : 0;
      exp_done = (t == 65537) ? 1 : 0;
      if (int'(contador_w) != exp_cnt || int'(pwm_w) != exp_pwm ||
          int'(busy_w) != exp_busy || int'(done_w) != exp_done) errs++;
      if (t == 32001) chk("wrap_pwm_below_half", 32'(pwm_w), 32'd0);
      if (t == 32002) chk("wrap_pwm_at_half", 32'(pwm_w), 32'd21);
      if (t == 65536) chk("wrap_contador_max", 32'(contador_w), 32'd65535);
      if (t == 65537) chk("wrap_contador_zero", 32'(contador_w), 32'd0);
      if (t == 65537) chk("wrap_done", 32'(done_w), 32'd1);
    end
    chk("wrap_cycle_errors", 32'(errs), 32'd0);
  endtask

  initial begin
    fork
      main_test();
      wrap_test();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
